// File: rtl/bf16_pkg.sv
// bf16_pkg: bfloat16 types, constants and operand classification shared by the
// bfloat16 multiplier and divider.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NORMAL} bf16_cls_e;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} div_state_e;

    localparam int          BF16_BIAS    = 127;
    localparam logic [15:0] BF16_QNAN    = 16'hFFFF;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;

    // Exponent 0 flushes to zero and exponent 0xFF is Inf whatever the mantissa.
    function automatic bf16_cls_e bf16_classify(input bf16_t x);
        return x.exp == 8'h00 ? CLS_ZERO : x.exp == BF16_EXP_MAX ? CLS_INF : CLS_NORMAL;
    endfunction

endpackage

// File: rtl/bf16_mant_div_step.sv
// bf16_mant_div_step: one restoring-division step producing a quotient bit and the
// shifted partial remainder.
module bf16_mant_div_step (
    input  logic [8:0] rem_i,
    input  logic [7:0] div_i,
    output logic       q_o,
    output logic [8:0] rem_o
);

    logic [7:0] diff;

    // The reduced remainder is always below the divisor, so it fits in 8 bits.
    always_comb begin
        q_o   = rem_i >= {1'b0, div_i};
        diff  = q_o ? 8'(rem_i - {1'b0, div_i}) : rem_i[7:0];
        rem_o = {diff, 1'b0};
    end

endmodule

// File: rtl/bfloat16_div_seq.sv
// bfloat16_div_seq: sequential bfloat16 divider, one quotient bit per cycle, truncating.
// Define BF16_DIV_RNE_EN for an extra guard-bit cycle and round-to-nearest-even.
module bfloat16_div_seq
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] c,
    output logic [3:0]  flags
);

    localparam int QBITS = 9;
    localparam int BIAS  = BF16_BIAS;
`ifdef BF16_DIV_RNE_EN
    localparam int NCYC = QBITS + 1;
`else
    localparam int NCYC = QBITS;
`endif

    div_state_e        state_q, state_d;
    logic [8:0]        rem_q, rem_d, step_rem;
    logic [7:0]        div_q, div_d;
    logic [NCYC-1:0]   q_q, q_d;
    logic [3:0]        cnt_q, cnt_d;
    logic signed [9:0] e_q, e_d, en;
    logic              s_q, s_d, step_q, special, nv, rnd;
    logic [15:0]       c_q, c_d, spec_c, norm_c;
    logic [3:0]        flags_q, flags_d, spec_f, norm_f;
    logic [8:0]        qm;
    logic [7:0]        frac_r;
    bf16_cls_e         ca, cb;

    bf16_mant_div_step u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .q_o   (step_q),
        .rem_o (step_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            s_q     <= 1'b0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            s_q     <= s_d;
            c_q     <= c_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        ca      = bf16_classify(bf16_t'(a));
        cb      = bf16_classify(bf16_t'(b));
        special = ca != CLS_NORMAL || cb != CLS_NORMAL;
        nv      = (ca == CLS_ZERO && cb == CLS_ZERO) || (ca == CLS_INF && cb == CLS_INF);
        spec_c  = nv ? BF16_QNAN
                : (cb == CLS_ZERO || ca == CLS_INF) ? {a[15] ^ b[15], BF16_EXP_MAX, 7'h0}
                : 16'h0000;
        spec_f  = {nv, !nv && cb == CLS_ZERO, 2'b00};
    end

    // Normalise the quotient; with rounding, the guard bit sits one below the kept frac.
    always_comb begin
`ifdef BF16_DIV_RNE_EN
        qm  = q_q[9:1];
        rnd = (qm[8] ? qm[0] : q_q[0])
            & ((qm[8] & q_q[0]) | (rem_q != 9'd0) | (qm[8] ? qm[1] : qm[0]));
`else
        qm  = q_q;
        rnd = 1'b0;
`endif
        frac_r = {1'b0, qm[8] ? qm[7:1] : qm[6:0]} + {7'd0, rnd};
        en     = e_q - {9'd0, ~qm[8]} + {9'd0, frac_r[7]};
        norm_c = en >= 10'sd255 ? {s_q, BF16_EXP_MAX, 7'h0}
               : en <= 10'sd0   ? 16'h0000
               : {s_q, en[7:0], frac_r[6:0]};
        norm_f = {2'b00, en >= 10'sd255, en <= 10'sd0};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = special ? DONE : DIV;
            DIV:     if (cnt_q == 4'(NCYC - 1)) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        s_d     = s_q;
        c_d     = c_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (in_valid) begin
                s_d     = a[15] ^ b[15];
                e_d     = 10'({2'b00, a[14:7]} - {2'b00, b[14:7]} + 10'(BIAS));
                rem_d   = {2'b01, a[6:0]};
                div_d   = {1'b1, b[6:0]};
                q_d     = '0;
                cnt_d   = '0;
                c_d     = special ? spec_c : c_q;
                flags_d = special ? spec_f : 4'b0000;
            end
            DIV: begin
                rem_d = step_rem;
                q_d   = {q_q[NCYC-2:0], step_q};
                cnt_d = cnt_q + 4'd1;
            end
            NORM: begin
                c_d     = norm_c;
                flags_d = norm_f;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        c         = c_q;
        flags     = flags_q;
    end

endmodule

// File: tb/tb_bfloat16_div_seq.sv
// tb_bfloat16_div_seq: randomized and directed check of bfloat16_div_seq against an
// arithmetic reference model; honours BF16_DIV_RNE_EN.
module tb_bfloat16_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready, out_valid;
    logic [15:0] c;
    logic [3:0]  flags;

    int vecs = 0;
    int errs = 0;

`ifdef BF16_DIV_RNE_EN
    localparam int          LAT     = 12;
    localparam logic [15:0] C_THIRD = 16'h3EAB;
`else
    localparam int          LAT     = 11;
    localparam logic [15:0] C_THIRD = 16'h3EAA;
`endif

    bfloat16_div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Quotient of the integer significands scaled by 2^8 (2^9 with a guard bit).
    function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] rc, output logic [3:0] rf,
                                    output int lat);
        int ex, ey, mx, my, e, q, fr, sh, drop, half;
        bit s, st;
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        s  = x[15] ^ y[15];
        rf = 4'b0000;
        lat = 1;
        rc = 16'h0000;
        if ((ex == 0 && ey == 0) || (ex == 255 && ey == 255)) begin
            rc = 16'hFFFF;
            rf = 4'b1000;
        end else if (ey == 0) begin
            rc = {s, 8'hFF, 7'h0};
            rf = 4'b0100;
        end else if (ex == 255) begin
            rc = {s, 8'hFF, 7'h0};
        end else if (ex == 0 || ey == 255) begin
            rc = 16'h0000;
        end else begin
            lat = LAT;
            mx = 128 + int'(x[6:0]);
            my = 128 + int'(y[6:0]);
            e  = ex - ey + 127;
`ifdef BF16_DIV_RNE_EN
            q  = (mx << 9) / my;
            st = ((mx << 9) % my) != 0;
            sh = q >= 512 ? 2 : 1;
            if (q < 512) e = e - 1;
            fr   = q >> sh;
            drop = q & ((1 << sh) - 1);
            half = 1 << (sh - 1);
            if (drop > half || (drop == half && (st || (fr & 1) == 1))) fr = fr + 1;
            if (fr == 256) begin
                fr = 128;
                e  = e + 1;
            end
`else
            q  = (mx << 8) / my;
            st = 1'b0;
            sh = 0;
            drop = 0;
            half = 0;
            if (q >= 256) fr = q >> 1;
            else begin
                fr = q;
                e  = e - 1;
            end
`endif
            if (e >= 255) begin
                rc = {s, 8'hFF, 7'h0};
                rf = 4'b0010;
            end else if (e <= 0) begin
                rc = 16'h0000;
                rf = 4'b0001;
            end else begin
                rc = {s, 8'(e), 7'(fr)};
            end
        end
    endfunction

    // Accepts one operation and waits for out_valid; leaves the result pending in DONE.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] rc, output logic [3:0] rf, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rc = c;
        rf = flags;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_check(input string tag, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] rc, ec;
        logic [3:0]  rf, ef;
        int          lat, elat;
        run_op(x, y, rc, rf, lat);
        ref_div(x, y, ec, ef, elat);
        check({tag, " c"}, rc, ec);
        check({tag, " flags"}, rf, ef);
        check({tag, " lat"}, lat, elat);
        release_result();
    endtask

    function automatic logic [15:0] rnd_bf16();
        logic [7:0] e;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    typedef struct {
        logic [15:0] x, y, c;
        logic [3:0]  f;
        int          lat;
    } dir_t;

    dir_t dirs[$];

    initial begin
        logic [15:0] rc;
        logic [3:0]  rf;
        int          lat;

        dirs = '{
            '{16'h40C0, 16'h4000, 16'h4040, 4'b0000, LAT},
            '{16'hC0C0, 16'h4000, 16'hC040, 4'b0000, LAT},
            '{16'h3F80, 16'h4040, C_THIRD,  4'b0000, LAT},
            '{16'h3F80, 16'h0000, 16'h7F80, 4'b0100, 1},
            '{16'h0000, 16'h0000, 16'hFFFF, 4'b1000, 1},
            '{16'h7F80, 16'h7F80, 16'hFFFF, 4'b1000, 1},
            '{16'h3F80, 16'h7F80, 16'h0000, 4'b0000, 1},
            '{16'hFF80, 16'h3F80, 16'hFF80, 4'b0000, 1},
            '{16'h7F00, 16'h3E80, 16'h7F80, 4'b0010, LAT},
            '{16'h0080, 16'h4000, 16'h0000, 4'b0001, LAT}
        };

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset c", c, 16'h0000);
        check("reset flags", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dirs[i]) begin
            run_op(dirs[i].x, dirs[i].y, rc, rf, lat);
            check($sformatf("dir%0d c", i), rc, dirs[i].c);
            check($sformatf("dir%0d flags", i), rf, dirs[i].f);
            check($sformatf("dir%0d lat", i), lat, dirs[i].lat);
            release_result();
            do_check($sformatf("dirmodel%0d", i), dirs[i].x, dirs[i].y);
        end

        // Result held in DONE while new operands are offered and ignored.
        run_op(16'h40C0, 16'h4000, rc, rf, lat);
        a = 16'h3F80;
        b = 16'h4040;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("hold c", c, 16'h4040);
            check("hold in_ready", in_ready, 1'b0);
            check("hold out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after pop in_ready", in_ready, 1'b1);
        check("after pop out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("reaccept c", c, C_THIRD);
        check("reaccept lat", lat, LAT);
        release_result();

        // Asynchronous reset in the middle of the division loop.
        a = 16'h40C0;
        b = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset in_ready", in_ready, 1'b1);
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset c", c, 16'h0000);
        check("midreset flags", flags, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h40C0, 16'h4000, rc, rf, lat);
        check("post reset c", rc, 16'h4040);
        check("post reset flags", rf, 4'b0000);
        check("post reset lat", lat, LAT);
        release_result();

        for (int i = 0; i < 200; i++) do_check($sformatf("rnd%0d", i), rnd_bf16(), rnd_bf16());

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
